// File: rtl/sp_request_fifo.sv
// rtl/sp_request_fifo.sv - speculative scratchpad request FIFO
//
// Circular-buffer FIFO between execute and the scratchpad. Each entry carries
// a spec bit; speculative entries are held back from the consumer until the
// branch resolves (spec_clear) or are discarded from the tail (spec_flush).
//
// Optional feature macro: SP_FIFO_BYPASS_EN (empty-FIFO combinational bypass).
//
// Ports:
//   CLK        sole clock, rising edge
//   RST        asynchronous active-high reset
//   wen        push request
//   wdata      entry to push ([37:36] op, [35:32] rd, [31:0] addr/select)
//   wspec      pushed entry is speculative
//   spec_clear all entries become non-speculative
//   spec_flush discard all speculative entries
//   full       count == DEPTH (registered)
//   rvalid     head entry present and non-speculative
//   rdata      head entry payload
//   rready     consumer accepts head
//   count      occupied entries
//   overflow   sticky: push attempted while full
module sp_request_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 38
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wen,
  input  logic [EW-1:0]              wdata,
  input  logic                       wspec,
  input  logic                       spec_clear,
  input  logic                       spec_flush,
  output logic                       full,
  output logic                       rvalid,
  output logic [EW-1:0]              rdata,
  input  logic                       rready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] spec_q;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             full_q;
  logic             overflow_q;

  logic [CW-1:0]    n_spec;
  logic [CW-1:0]    count_next;
  logic             stored_valid;
  logic             bypass;
  logic             push;
  logic             pop;

  // Spec bits of free slots are always zero (cleared on flush/clear, and a
  // popped head is never speculative), so a plain popcount gives the number
  // of speculative entries currently queued.
  always_comb begin
    n_spec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_spec = n_spec + CW'(spec_q[i]);
    end
  end

  assign stored_valid = (count_q != '0) && !spec_q[head_q];

`ifdef SP_FIFO_BYPASS_EN
  // Empty FIFO, consumer ready: hand the entry straight through unstored.
  assign bypass = (count_q == '0) && wen && !wspec && !spec_flush && rready;
`else
  assign bypass = 1'b0;
`endif

  assign push = wen && !full_q && !spec_flush && !bypass;
  assign pop  = stored_valid && rready;

  assign count_next = count_q + CW'(push) - CW'(pop) - (spec_flush ? n_spec : '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      spec_q     <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wen && full_q) begin
        overflow_q <= 1'b1;
      end

      if (pop) begin
        head_q <= head_q + AW'(1);
      end

      if (spec_flush) begin
        // Speculative entries are contiguous at the tail: rewind over them.
        // n_spec == DEPTH truncates to zero, which is the correct full wrap.
        tail_q <= tail_q - AW'(n_spec);
        spec_q <= '0;
      end else begin
        if (spec_clear) begin
          spec_q <= '0;
        end
        if (push) begin
          mem[tail_q]    <= wdata;
          spec_q[tail_q] <= wspec;
          tail_q         <= tail_q + AW'(1);
        end
      end

      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
    end
  end

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rvalid   = stored_valid || bypass;
  assign rdata    = bypass ? wdata : mem[head_q];

endmodule

// File: tb/tb_sp_request_fifo.sv
// tb/tb_sp_request_fifo.sv - scoreboard bench for sp_request_fifo
module tb_sp_request_fifo;

  localparam int DEPTH = 4;
  localparam int EW    = 38;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          wen = 1'b0;
  logic [EW-1:0] wdata = '0;
  logic          wspec = 1'b0;
  logic          spec_clear = 1'b0;
  logic          spec_flush = 1'b0;
  logic          full;
  logic          rvalid;
  logic [EW-1:0] rdata;
  logic          rready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;

  sp_request_fifo #(.DEPTH(DEPTH), .EW(EW)) dut (
    .CLK(CLK), .RST(RST), .wen(wen), .wdata(wdata), .wspec(wspec),
    .spec_clear(spec_clear), .spec_flush(spec_flush), .full(full),
    .rvalid(rvalid), .rdata(rdata), .rready(rready), .count(count),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [EW-1:0] d;
    bit            s;
  } ent_t;

  ent_t          mq[$];     // reference model contents, oldest first
  logic [EW-1:0] sb[$];     // scoreboard: expected rdata on each handshake
  bit            m_ovf = 1'b0;
  bit            m_byp = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit model_has_spec();
    foreach (mq[i]) if (mq[i].s) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every accepted head must match the oldest outstanding entry.
  always @(negedge CLK) begin
    if (!RST && rvalid && rready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected actual=%0h expected=none", rdata);
      end else begin
        chk("rdata", 64'(rdata), 64'(sb.pop_front()));
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit w, input logic [EW-1:0] d, input bit ws,
                      input bit clr, input bit fl, input bit rr);
    bit m_full;
    bit m_pop;
    bit m_rv;
    wen = w; wdata = d; wspec = ws; spec_clear = clr; spec_flush = fl; rready = rr;
`ifdef SP_FIFO_BYPASS_EN
    m_byp = (mq.size() == 0) && w && !ws && !fl && rr;
`else
    m_byp = 1'b0;
`endif
    if (m_byp) sb.push_back(d);
    m_full = (mq.size() == DEPTH);
    m_rv   = (mq.size() > 0 && !mq[0].s) || m_byp;
    @(negedge CLK);
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(m_full));
    chk("rvalid", 64'(rvalid), 64'(m_rv));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    @(posedge CLK);
    m_pop = mq.size() > 0 && !mq[0].s && rr;
    if (w && m_full) m_ovf = 1'b1;
    if (m_pop) void'(mq.pop_front());
    if (fl) begin
      while (mq.size() > 0 && mq[mq.size()-1].s) begin
        void'(mq.pop_back());
        void'(sb.pop_back());
      end
    end else begin
      if (clr) begin
        foreach (mq[i]) begin
          ent_t e = mq[i];
          e.s = 1'b0;
          mq[i] = e;
        end
      end
      if (w && !m_full && !m_byp) begin
        ent_t n;
        n.d = d;
        n.s = ws;
        mq.push_back(n);
        sb.push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle(input bit rr);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, rr);
  endtask

  task automatic reset_pulse();
    wen = 1'b0; spec_clear = 1'b0; spec_flush = 1'b0; rready = 1'b0;
    RST = 1'b1;
    #2;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    #1;
    RST = 1'b0;
    mq.delete();
    sb.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    #2;
    chk("init_count", 64'(count), 64'(0));
    chk("init_full", 64'(full), 64'(0));
    chk("init_rvalid", 64'(rvalid), 64'(0));
    chk("init_overflow", 64'(overflow), 64'(0));
    chk("init_rdata", 64'(rdata), 64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Fill past capacity with consumer stalled, then drain.
    for (int i = 1; i <= 5; i++) step(1'b1, EW'(38'h1_0_0000_0100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Order and pointer wrap: 8 entries through a 4-deep buffer.
    for (int i = 1; i <= 8; i++) step(1'b1, EW'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush: A kept, B and C discarded, D lands right after A.
    step(1'b1, 38'h1_1_0000_000A, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 38'h2_2_0000_000B, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 38'h3_3_0000_000C, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 38'h1_4_0000_000D, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Clear: speculative head held back until resolved.
    step(1'b1, 38'h2_5_0000_00B0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Clear with a same-cycle speculative push; flush with a same-cycle pop.
    step(1'b1, 38'h1_6_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 38'h1_6_0000_0002, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 38'h1_6_0000_0003, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Empty-FIFO push with consumer ready.
    step(1'b1, 38'h3_0_0000_0002, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-run with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, EW'(38'h1_7_0000_0000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    reset_pulse();
    idle(1'b1);

    // Randomised traffic respecting in-order speculation.
    for (int n = 0; n < 600; n++) begin
      bit w, ws, clr, fl, rr;
      logic [EW-1:0] d;
      w   = ($urandom_range(0, 2) != 0);
      rr  = ($urandom_range(0, 1) != 0);
      clr = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      ws  = ($urandom_range(0, 2) == 0);
      if (model_has_spec() && !clr) ws = 1'b1;
      d   = EW'({$urandom(), $urandom()});
      step(w, d, ws, clr, fl, rr);
      if (n == 300) reset_pulse();
    end

    // Resolve and drain whatever remains.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("drain_scoreboard", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
